// File: rtl/matrix_pkg.sv
// Shared definitions for the matrix MAC engine: bus regions, CTRL/STATUS
// field offsets and the sequencer state encoding.
package matrix_pkg;

  localparam logic [2:0] RGN_CTRL   = 3'd0;
  localparam logic [2:0] RGN_A      = 3'd1;
  localparam logic [2:0] RGN_B      = 3'd2;
  localparam logic [2:0] RGN_C      = 3'd3;
  localparam logic [2:0] RGN_STATUS = 3'd4;

  localparam int CTRL_ROWS_LSB   = 0;
  localparam int CTRL_INNER_LSB  = 8;
  localparam int CTRL_COLS_LSB   = 16;
  localparam int CTRL_START_BIT  = 24;
  localparam int CTRL_SIGNED_BIT = 25;
  localparam int CTRL_ACCUM_BIT  = 26;
  localparam int CTRL_SAT_BIT    = 27;
  localparam int CTRL_IRQ_EN_BIT = 28;

  localparam int STAT_DONE_BIT = 0;
  localparam int STAT_BUSY_BIT = 1;
  localparam int STAT_ERR_BIT  = 2;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_INIT,
    ST_MAC,
    ST_WB,
    ST_DONE
  } state_t;

endpackage

// File: rtl/matrix_mac_unit.sv
// Multiply-accumulate datapath: full-precision accumulator plus the
// saturate/truncate reduction back to element width.
module matrix_mac_unit #(
  parameter int DATA_W    = 32,
  parameter int INNER_MAX = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              load,
  input  logic              mac_en,
  input  logic              is_signed,
  input  logic              accum,
  input  logic              sat,
  input  logic [DATA_W-1:0] c_init,
  input  logic [DATA_W-1:0] a,
  input  logic [DATA_W-1:0] b,
  output logic [DATA_W-1:0] wb_data
);

  localparam int ACC_W  = 2*DATA_W + $clog2(INNER_MAX) + 1;
  localparam int PROD_W = 2*DATA_W + 2;

  logic signed [DATA_W:0]   a_ext, b_ext, c_sx;
  logic signed [PROD_W-1:0] prod;
  logic signed [ACC_W-1:0]  prod_acc, c_ext;
  logic signed [ACC_W-1:0]  acc_p0;

  // One spare top bit lets the same signed multiplier serve both modes.
  assign a_ext    = {is_signed & a[DATA_W-1], a};
  assign b_ext    = {is_signed & b[DATA_W-1], b};
  assign c_sx     = {is_signed & c_init[DATA_W-1], c_init};
  assign prod     = PROD_W'(a_ext) * PROD_W'(b_ext);
  assign prod_acc = ACC_W'(prod);
  assign c_ext    = ACC_W'(c_sx);

  function automatic logic [DATA_W-1:0] clamp_acc(input logic signed [ACC_W-1:0] v,
                                                  input logic sgn);
    logic signed [ACC_W-1:0] hi, lo;
    hi = sgn ? (ACC_W'(1) <<< (DATA_W-1)) - ACC_W'(1) : (ACC_W'(1) <<< DATA_W) - ACC_W'(1);
    lo = sgn ? -(ACC_W'(1) <<< (DATA_W-1)) : '0;
    if (v > hi)      return hi[DATA_W-1:0];
    else if (v < lo) return lo[DATA_W-1:0];
    else             return v[DATA_W-1:0];
  endfunction

  function automatic logic [DATA_W-1:0] trunc_acc(input logic signed [ACC_W-1:0] v);
    return v[DATA_W-1:0];
  endfunction

  // Stage p0: accumulator register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      acc_p0 <= '0;
    end else if (load) begin
      acc_p0 <= accum ? c_ext : '0;
    end else if (mac_en) begin
      acc_p0 <= acc_p0 + prod_acc;
    end
  end

  assign wb_data = sat ? clamp_acc(acc_p0, is_signed) : trunc_acc(acc_p0);

endmodule

// File: rtl/matrix_mac_engine.sv
// Bus-programmed matrix multiply-accumulate engine: C = A*B (+C), one
// output element per INIT/MAC/WB pass, with sticky done/err status.
module matrix_mac_engine
  import matrix_pkg::*;
#(
  parameter int DATA_W    = 32,
  parameter int ROWS_MAX  = 4,
  parameter int INNER_MAX = 4,
  parameter int COLS_MAX  = 4
) (
  input  logic        i_clk,
  input  logic        m_rst_t,
  input  logic        i_sel,
  input  logic        i_we,
  input  logic [10:0] i_addr,
  input  logic [31:0] i_data,
  output logic [31:0] o_rdt,
  output logic        o_irq
);

  localparam int A_DEPTH = ROWS_MAX * INNER_MAX;
  localparam int B_DEPTH = INNER_MAX * COLS_MAX;
  localparam int C_DEPTH = ROWS_MAX * COLS_MAX;
  localparam int A_AW = (A_DEPTH > 1) ? $clog2(A_DEPTH) : 1;
  localparam int B_AW = (B_DEPTH > 1) ? $clog2(B_DEPTH) : 1;
  localparam int C_AW = (C_DEPTH > 1) ? $clog2(C_DEPTH) : 1;

  logic [DATA_W-1:0] a_mem [A_DEPTH];
  logic [DATA_W-1:0] b_mem [B_DEPTH];
  logic [DATA_W-1:0] c_mem [C_DEPTH];

  state_t     state;
  logic [7:0] rows, inner, cols;
  logic       sgn_mode, accum, sat, irq_en;
  logic       done, busy, err;
  logic [7:0] ci, cj, ck;

  logic [2:0]  region;
  logic [7:0]  idx;
  logic        wr, rd, cfg_wr, start_req, dims_ok;
  logic [7:0]  new_rows, new_inner, new_cols;
  logic [31:0] rd_data;
  logic        unused_data;
  logic [A_AW-1:0]   a_ridx;
  logic [B_AW-1:0]   b_ridx;
  logic [C_AW-1:0]   c_ridx;
  logic [DATA_W-1:0] wb_data;

  assign region      = i_addr[10:8];
  assign idx         = i_addr[7:0];
  assign wr          = i_sel & i_we;
  assign rd          = i_sel & ~i_we;
  assign cfg_wr      = wr & ~busy;
  assign unused_data = ^i_data[31:29];

  assign new_rows  = i_data[CTRL_ROWS_LSB +: 8];
  assign new_inner = i_data[CTRL_INNER_LSB +: 8];
  assign new_cols  = i_data[CTRL_COLS_LSB +: 8];
  assign start_req = cfg_wr && (region == RGN_CTRL) && i_data[CTRL_START_BIT];
  assign dims_ok   = (new_rows != 8'd0) && (int'(new_rows) <= ROWS_MAX) &&
                     (new_inner != 8'd0) && (int'(new_inner) <= INNER_MAX) &&
                     (new_cols != 8'd0) && (int'(new_cols) <= COLS_MAX);

  // Compact row-major addressing by the programmed dimensions.
  assign a_ridx = A_AW'(16'(ci) * 16'(inner) + 16'(ck));
  assign b_ridx = B_AW'(16'(ck) * 16'(cols) + 16'(cj));
  assign c_ridx = C_AW'(16'(ci) * 16'(cols) + 16'(cj));

  matrix_mac_unit #(
    .DATA_W    (DATA_W),
    .INNER_MAX (INNER_MAX)
  ) u_mac (
    .clk       (i_clk),
    .rst       (m_rst_t),
    .load      (state == ST_INIT),
    .mac_en    (state == ST_MAC),
    .is_signed (sgn_mode),
    .accum     (accum),
    .sat       (sat),
    .c_init    (c_mem[c_ridx]),
    .a         (a_mem[a_ridx]),
    .b         (b_mem[b_ridx]),
    .wb_data   (wb_data)
  );

  function automatic logic [31:0] elem_ext(input logic [DATA_W-1:0] e, input logic sgn);
    return sgn ? 32'(signed'(e)) : 32'(e);
  endfunction

  always_comb begin
    rd_data = '0;
    case (region)
      RGN_CTRL: begin
        rd_data[CTRL_ROWS_LSB +: 8]  = rows;
        rd_data[CTRL_INNER_LSB +: 8] = inner;
        rd_data[CTRL_COLS_LSB +: 8]  = cols;
        rd_data[CTRL_SIGNED_BIT]     = sgn_mode;
        rd_data[CTRL_ACCUM_BIT]      = accum;
        rd_data[CTRL_SAT_BIT]        = sat;
        rd_data[CTRL_IRQ_EN_BIT]     = irq_en;
      end
      RGN_A: if (int'(idx) < A_DEPTH) rd_data = elem_ext(a_mem[A_AW'(idx)], sgn_mode);
      RGN_B: if (int'(idx) < B_DEPTH) rd_data = elem_ext(b_mem[B_AW'(idx)], sgn_mode);
      RGN_C: if (int'(idx) < C_DEPTH) rd_data = elem_ext(c_mem[C_AW'(idx)], sgn_mode);
      RGN_STATUS: begin
        rd_data[STAT_DONE_BIT] = done;
        rd_data[STAT_BUSY_BIT] = busy;
        rd_data[STAT_ERR_BIT]  = err;
      end
      default: ;
    endcase
  end

  always_ff @(posedge i_clk or posedge m_rst_t) begin
    if (m_rst_t) begin
      o_rdt <= '0;
    end else if (rd) begin
      o_rdt <= rd_data;
    end
  end

  // Element storage survives reset; write-back only happens while busy,
  // when bus writes are locked out, so the two never collide.
  always_ff @(posedge i_clk) begin
    if (cfg_wr) begin
      case (region)
        RGN_A: if (int'(idx) < A_DEPTH) a_mem[A_AW'(idx)] <= i_data[DATA_W-1:0];
        RGN_B: if (int'(idx) < B_DEPTH) b_mem[B_AW'(idx)] <= i_data[DATA_W-1:0];
        RGN_C: if (int'(idx) < C_DEPTH) c_mem[C_AW'(idx)] <= i_data[DATA_W-1:0];
        default: ;
      endcase
    end
    if (state == ST_WB) c_mem[c_ridx] <= wb_data;
  end

  always_ff @(posedge i_clk or posedge m_rst_t) begin
    if (m_rst_t) begin
      state    <= ST_IDLE;
      rows     <= '0;
      inner    <= '0;
      cols     <= '0;
      sgn_mode <= 1'b0;
      accum    <= 1'b0;
      sat      <= 1'b0;
      irq_en   <= 1'b0;
      done     <= 1'b0;
      busy     <= 1'b0;
      err      <= 1'b0;
      ci       <= '0;
      cj       <= '0;
      ck       <= '0;
    end else begin
      if (cfg_wr && region == RGN_CTRL) begin
        rows     <= new_rows;
        inner    <= new_inner;
        cols     <= new_cols;
        sgn_mode <= i_data[CTRL_SIGNED_BIT];
        accum    <= i_data[CTRL_ACCUM_BIT];
        sat      <= i_data[CTRL_SAT_BIT];
        irq_en   <= i_data[CTRL_IRQ_EN_BIT];
      end
      if (wr && region == RGN_STATUS) begin
        done <= 1'b0;
        err  <= 1'b0;
      end
      case (state)
        ST_IDLE: begin
          if (start_req) begin
            if (dims_ok) begin
              state <= ST_INIT;
              busy  <= 1'b1;
              done  <= 1'b0;
              ci    <= '0;
              cj    <= '0;
              ck    <= '0;
            end else begin
              err <= 1'b1;
            end
          end
        end
        ST_INIT: begin
          ck    <= '0;
          state <= ST_MAC;
        end
        ST_MAC: begin
          if (ck == inner - 8'd1) state <= ST_WB;
          else                    ck    <= ck + 8'd1;
        end
        ST_WB: begin
          if (cj == cols - 8'd1) begin
            cj <= '0;
            if (ci == rows - 8'd1) begin
              state <= ST_DONE;
              busy  <= 1'b0;
              done  <= 1'b1;
            end else begin
              ci    <= ci + 8'd1;
              state <= ST_INIT;
            end
          end else begin
            cj    <= cj + 8'd1;
            state <= ST_INIT;
          end
        end
        ST_DONE: state <= ST_IDLE;
        default: state <= ST_IDLE;
      endcase
    end
  end

  assign o_irq = done & irq_en;

endmodule

// File: tb/tb_matrix_mac_engine.sv
// Scoreboard bench for matrix_mac_engine (DATA_W=8): reads push expected
// data into a queue, a monitor compares o_rdt the cycle after each read.
module tb_matrix_mac_engine;
  import matrix_pkg::*;

  logic        clk = 1'b0;
  logic        m_rst_t;
  logic        sel, we;
  logic [10:0] addr;
  logic [31:0] data;
  logic [31:0] rdt;
  logic        irq;

  int pass_cnt = 0;
  int total_cnt = 0;

  typedef struct {
    string       name;
    logic [31:0] exp;
  } exp_t;
  exp_t sbq[$];
  logic rd_pend = 1'b0;

  matrix_mac_engine #(
    .DATA_W(8), .ROWS_MAX(4), .INNER_MAX(4), .COLS_MAX(4)
  ) dut (
    .i_clk   (clk),
    .m_rst_t (m_rst_t),
    .i_sel   (sel),
    .i_we    (we),
    .i_addr  (addr),
    .i_data  (data),
    .o_rdt   (rdt),
    .o_irq   (irq)
  );

  always #5 clk = ~clk;

  task automatic chk(input string n, input logic [31:0] act, input logic [31:0] exp);
    total_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got 0x%08h expected 0x%08h", n, act, exp);
  endtask

  always @(posedge clk) rd_pend <= sel & ~we;

  always @(negedge clk) begin
    if (rd_pend) begin
      if (sbq.size() == 0) begin
        chk("unexpected_read", rdt, 32'hDEAD_BEEF);
      end else begin
        exp_t e;
        e = sbq.pop_front();
        chk(e.name, rdt, e.exp);
      end
    end
  end

  task automatic wr(input logic [2:0] r, input logic [7:0] i, input logic [31:0] d);
    sel = 1'b1; we = 1'b1; addr = {r, i}; data = d;
    @(negedge clk);
    sel = 1'b0; we = 1'b0;
  endtask

  task automatic rd(input logic [2:0] r, input logic [7:0] i, input logic [31:0] e,
                    input string n);
    exp_t t;
    t.name = n; t.exp = e;
    sbq.push_back(t);
    sel = 1'b1; we = 1'b0; addr = {r, i};
    @(negedge clk);
    sel = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  logic [7:0] a3 [9] = '{8'hFF, 8'h02, 8'hFD, 8'h01, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00};
  logic [7:0] b3 [9] = '{8'h04, 8'h00, 8'h00, 8'h05, 8'h00, 8'h00, 8'h06, 8'h00, 8'h00};
  logic [7:0] a2 [4] = '{8'd1, 8'd2, 8'd3, 8'd4};
  logic [7:0] b2 [4] = '{8'd1, 8'd0, 8'd0, 8'd1};

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1);
  end

  initial begin
    m_rst_t = 1'b1; sel = 1'b0; we = 1'b0; addr = '0; data = '0;
    idle(2);
    #1;
    chk("rst_rdt", rdt, 32'h0);
    chk("rst_irq", {31'b0, irq}, 32'h0);
    @(negedge clk);
    m_rst_t = 1'b0;
    idle(1);
    rd(RGN_CTRL, 8'd0, 32'h0, "rst_ctrl");
    rd(RGN_STATUS, 8'd0, 32'h0, "rst_status");

    // 2x2 identity, irq enabled, exact busy length
    for (int n = 0; n < 4; n++) wr(RGN_A, 8'(n), 32'(a2[n]));
    for (int n = 0; n < 4; n++) wr(RGN_B, 8'(n), 32'(b2[n]));
    wr(RGN_CTRL, 8'd0, 32'h1102_0202);
    idle(15);
    rd(RGN_STATUS, 8'd0, 32'h2, "busy_last_cycle");
    rd(RGN_STATUS, 8'd0, 32'h1, "done_after_16");
    chk("irq_on_done", {31'b0, irq}, 32'h1);
    for (int n = 0; n < 4; n++) rd(RGN_C, 8'(n), 32'(a2[n]), "c_identity");
    rd(RGN_CTRL, 8'd0, 32'h1002_0202, "ctrl_start_reads0");
    wr(RGN_STATUS, 8'd0, 32'h0);
    chk("irq_cleared", {31'b0, irq}, 32'h0);
    rd(RGN_STATUS, 8'd0, 32'h0, "status_cleared");

    // signed 3x3, writes and restart attempted while busy
    for (int n = 0; n < 9; n++) wr(RGN_A, 8'(n), 32'(a3[n]));
    for (int n = 0; n < 9; n++) wr(RGN_B, 8'(n), 32'(b3[n]));
    wr(RGN_CTRL, 8'd0, 32'h0303_0303);
    idle(2);
    wr(RGN_A, 8'd8, 32'h1);
    wr(RGN_CTRL, 8'd0, 32'h0101_0101);
    idle(60);
    rd(RGN_C, 8'd0, 32'hFFFF_FFF4, "signed_c00");
    rd(RGN_C, 8'd1, 32'h0, "signed_c01");
    rd(RGN_C, 8'd3, 32'h4, "signed_c10");
    rd(RGN_C, 8'd6, 32'h0, "busy_wr_ignored_c20");
    rd(RGN_A, 8'd8, 32'h0, "busy_wr_ignored_a8");
    rd(RGN_A, 8'd0, 32'hFFFF_FFFF, "a_sign_ext");
    rd(RGN_CTRL, 8'd0, 32'h0203_0303, "busy_ctrl_ignored");
    rd(RGN_STATUS, 8'd0, 32'h1, "signed_done_no_err");

    // saturation and truncation
    wr(RGN_A, 8'd0, 32'd100);
    wr(RGN_B, 8'd0, 32'd100);
    wr(RGN_CTRL, 8'd0, 32'h0B01_0101);
    idle(8);
    rd(RGN_C, 8'd0, 32'h7F, "sat_pos");
    wr(RGN_CTRL, 8'd0, 32'h0301_0101);
    idle(8);
    rd(RGN_C, 8'd0, 32'h10, "trunc");
    wr(RGN_A, 8'd0, 32'h9C);
    wr(RGN_CTRL, 8'd0, 32'h0B01_0101);
    idle(8);
    rd(RGN_C, 8'd0, 32'hFFFF_FF80, "sat_neg");
    wr(RGN_A, 8'd0, 32'd200);
    wr(RGN_B, 8'd0, 32'd200);
    wr(RGN_CTRL, 8'd0, 32'h0901_0101);
    idle(8);
    rd(RGN_C, 8'd0, 32'hFF, "sat_unsigned");

    // accumulate onto preloaded C
    wr(RGN_C, 8'd0, 32'd10);
    wr(RGN_A, 8'd0, 32'd1);
    wr(RGN_A, 8'd1, 32'd1);
    wr(RGN_B, 8'd0, 32'd2);
    wr(RGN_B, 8'd1, 32'd3);
    wr(RGN_CTRL, 8'd0, 32'h0501_0201);
    idle(10);
    rd(RGN_C, 8'd0, 32'd15, "accum");

    // bad dimensions
    wr(RGN_STATUS, 8'd0, 32'h0);
    wr(RGN_CTRL, 8'd0, 32'h0101_0001);
    rd(RGN_STATUS, 8'd0, 32'h4, "err_inner0");
    idle(3);
    rd(RGN_STATUS, 8'd0, 32'h4, "err_still_idle");
    wr(RGN_STATUS, 8'd0, 32'h0);
    rd(RGN_STATUS, 8'd0, 32'h0, "err_cleared");
    wr(RGN_CTRL, 8'd0, 32'h0101_0105);
    rd(RGN_STATUS, 8'd0, 32'h4, "err_rows5");
    wr(RGN_STATUS, 8'd0, 32'h0);

    // unmapped region and out-of-depth index
    rd(RGN_A, 8'd0, 32'h1, "a0_before_hole");
    rd(3'd5, 8'd0, 32'h0, "region5_zero");
    rd(RGN_A, 8'd1, 32'h1, "a1_before_oor");
    rd(RGN_A, 8'd20, 32'h0, "a_oor_zero");

    // reset mid-run
    wr(RGN_A, 8'd0, 32'h55);
    wr(RGN_CTRL, 8'd0, 32'h1104_0404);
    idle(5);
    rd(RGN_A, 8'd0, 32'h55, "a_before_reset");
    m_rst_t = 1'b1;
    #1;
    chk("midrst_rdt", rdt, 32'h0);
    chk("midrst_irq", {31'b0, irq}, 32'h0);
    @(negedge clk);
    m_rst_t = 1'b0;
    idle(1);
    rd(RGN_STATUS, 8'd0, 32'h0, "midrst_status");
    rd(RGN_CTRL, 8'd0, 32'h0, "midrst_ctrl");
    rd(RGN_A, 8'd0, 32'h55, "midrst_a_kept");

    idle(3);
    chk("sb_drain", 32'(sbq.size()), 32'h0);
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
